// File: rtl/conversor_pkg.sv
// Shared definitions for the serial/parallel converter family.
// Bit-order selectors and the counter-width helper used by both directions.
package conversor_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  // Width of a counter that must hold 0..width-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/registro_desplazamiento_param.sv
// Parametrised shift register feeding the serial-to-parallel converter.
// Exposes its next value so the parent can capture a word that includes the current bit.
module registro_desplazamiento_param
  import conversor_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             dato_i,
  output logic [WIDTH-1:0] sr_next_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] base;

  // Clear and shift together leave only the incoming bit, placed as the first bit of a word.
  always_comb begin
    base = clear_i ? '0 : sr_q;
    sr_d = base;
    if (shift_en_i) begin
      if (MSB_FIRST) begin
        sr_d = {base[WIDTH-2:0], dato_i};
      end else begin
        sr_d = {dato_i, base[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_next_o = sr_d;

endmodule

// File: rtl/conversor_serie_paralelo_param.sv
// Serial-to-parallel converter with bit qualifier, frame resync, valid/ready output
// and a sticky overrun flag.
module conversor_serie_paralelo_param
  import conversor_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  bit          MSB_FIRST = ORDER_MSB_FIRST,
  localparam int unsigned CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dato,
  input  logic             bit_valid,
  input  logic             frame_sync,
  input  logic             word_ready,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] q,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wv_q, wv_d;
  logic             ovr_q, ovr_d;
  logic             last_bit, complete, accept, drop;

  registro_desplazamiento_param #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk_i      (clk),
    .rst_i      (rst),
    .shift_en_i (bit_valid),
    .clear_i    (frame_sync),
    .dato_i     (dato),
    .sr_next_o  (sr_next)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // A resync on the last bit position abandons the word instead of completing it.
  assign complete = bit_valid & ~frame_sync & last_bit;
  assign accept   = wv_q & word_ready;
  assign drop     = complete & wv_q & ~word_ready;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    wv_d  = wv_q;
    ovr_d = ovr_q;

    if (frame_sync) begin
      cnt_d = bit_valid ? CNT_W'(1) : '0;
    end else if (bit_valid) begin
      cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
    end

    // A completion on the accept cycle replaces the consumed word and keeps valid high.
    if (complete && (!wv_q || word_ready)) begin
      q_d  = sr_next;
      wv_d = 1'b1;
    end else if (accept) begin
      wv_d = 1'b0;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end else if (clear_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= '0;
      wv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
      wv_q  <= wv_d;
      ovr_q <= ovr_d;
    end
  end

  assign q          = q_q;
  assign word_valid = wv_q;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/conversor_serie_paralelo_param.md
Name: conversor_serie_paralelo_param

Overview:
Parametrised serial-to-parallel converter, the successor of the fixed 8-bit converter. It assembles WIDTH serial bits, selectable MSB- or LSB-first, into a parallel word and publishes it on a valid/ready handshake. It adds a bit-enable qualifier, frame resynchronisation, a bit-position counter and a sticky overrun flag. It sits between a serial receive front end and word-oriented consumers.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = first received bit lands in q[WIDTH-1]; 0 = first received bit lands in q[0].
CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
clk  input  1  single system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
dato  input  1  serial data bit; sampled only when bit_valid=1.
bit_valid  input  1  qualifies dato for this cycle.
frame_sync  input  1  restarts word assembly at bit position 0.
word_ready  input  1  consumer accepts q this cycle.
clear_ovr  input  1  clears the sticky overrun flag.
q  output  WIDTH  last completed word; held stable while word_valid=1.
word_valid  output  1  q holds an unconsumed word.
bit_count  output  CNT_W  number of bits collected in the current partial word.
overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset: one clk with rst=1 sets sr=0, bit_count=0, q=0, word_valid=0 and overrun=0. rst has priority over all other inputs. A reset mid-word discards the partial word.
- Shift when bit_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], dato}.
  - MSB_FIRST=0: sr <= {dato, sr[WIDTH-1:1]}.
  - bit_count increments.
  - When bit_valid=0, sr and bit_count hold.
- Completion: bit_valid=1 while bit_count==WIDTH-1.
  - The assembled word includes the current bit.
  - bit_count wraps to 0.
  - q and word_valid update on the same edge, so latency is 1 clk after the last bit is sampled.
- Handshake: the transfer occurs on a cycle with word_valid=1 and word_ready=1; that edge clears word_valid.
  - word_ready is ignored while word_valid=0.
  - q never changes while word_valid=1, except by an accepted-then-replaced completion (below).
- Completion with word_ready=1 on the same cycle: the old word is consumed, the new word loads into q, word_valid stays 1, no overrun.
- Completion while word_valid=1 and word_ready=0: the new word is dropped, q keeps the old word, and overrun is set to 1.
- overrun clears only on clear_ovr=1 or rst.
  - If clear_ovr=1 coincides with a new overrun event, set wins (overrun=1).
- frame_sync=1, bit_valid=0: bit_count <= 0 and sr <= 0; q and word_valid are unaffected.
- frame_sync=1 with bit_valid=1: the current bit is treated as bit 0 of a new word. bit_count <= 1 and sr holds only that bit.
  - If frame_sync arrives at bit_count==WIDTH-1, no completion occurs and the partial word is discarded.
- bit_count always lies in 0..WIDTH-1; it never reaches WIDTH.

Decomposition:
- Shared package conversor_pkg holds the MSB_FIRST/LSB_FIRST constants and a function computing CNT_W from WIDTH, reused by the future parallel-to-serial converter.
- One natural sub-module: registro_desplazamiento_param. It takes WIDTH, MSB_FIRST, shift-enable and clear, and contains sr only.
- The parent holds the counter, output register, handshake and overrun logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive bit_valid cycles, word_ready=1 -> q=8'hB2 and word_valid=1 one clk after the 8th bit; cleared on the next edge.
- WIDTH=8, MSB_FIRST=0, same bit sequence -> q=8'h4D.
- Two words back-to-back (8'hB2 then 8'h0F) with word_ready=0 -> q stays 8'hB2, overrun=1. Then word_ready=1 -> word_valid=0, overrun stays 1. Then clear_ovr=1 -> overrun=0.
- Send 5 bits, then frame_sync=1 with bit_valid=1 and dato=1, then 7 more bits 1,1,1,1,1,1,1 -> exactly one word, q=8'hFF; the first 5 bits are absent.
- bit_valid toggling 1,0,1,0 between bits of 8'hA5 -> q=8'hA5; bit_count holds during the gaps.
- rst=1 asserted at bit_count=4 with word_valid=1 -> next clk q=0, word_valid=0, bit_count=0, overrun=0; the next 8 bits form a fresh word.
